// File: rtl/sim_watchdog_pkg.sv
// Shared types for the simulation watchdog: FSM states, fail codes and
// a width helper for the per-cycle commit popcount.
package sim_watchdog_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_TIMEOUT = 2'd1,
    FC_MON     = 2'd2,
    FC_MEM     = 2'd3
  } fail_code_e;

  // Bits needed to hold a count of 0..channels.
  function automatic int popcnt_w(input int channels);
    return $clog2(channels + 1);
  endfunction

endpackage

// File: rtl/sim_watchdog_if.sv
// Bundle of the watchdog's run-control inputs and status outputs.
// The master side (test harness) drives commits and errors; the slave
// side (the watchdog) reports completion and counters.
interface sim_watchdog_if #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 64
);
  logic [CNT_W-1:0]    timeout_cfg;
  logic [CHANNELS-1:0] valid;
  logic [CHANNELS-1:0] halt;
  logic                mon_error;
  logic                mem_error;
  logic                done;
  logic                pass;
  logic [1:0]          fail_code;
  logic [CNT_W-1:0]    cycle_count;
  logic [CNT_W-1:0]    commit_count;

  modport master (
    output timeout_cfg, valid, halt, mon_error, mem_error,
    input  done, pass, fail_code, cycle_count, commit_count
  );

  modport slave (
    input  timeout_cfg, valid, halt, mon_error, mem_error,
    output done, pass, fail_code, cycle_count, commit_count
  );
endinterface

// File: rtl/sim_watchdog_popcnt.sv
// Number of set bits in the per-channel commit valid vector.
module sim_watchdog_popcnt
  import sim_watchdog_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int OUT_W    = popcnt_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] bits_i,
  output logic [OUT_W-1:0]    count_o
);

  // Adder chain over the channel bits.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count_o = count_o + OUT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/sim_watchdog.sv
// Simulation watchdog: ends a run as PASS on a qualified halt, or as FAIL
// on timeout or on a monitor/memory error (after a drain window).
// Counts elapsed cycles and committed instructions while the run is live.
module sim_watchdog
  import sim_watchdog_pkg::*;
#(
  parameter int CHANNELS     = 8,
  parameter int CNT_W        = 64,
  parameter int DRAIN_CYCLES = 5,
  parameter int IDLE_MODE    = 0
) (
  input logic          clk,
  input logic          rst,
  sim_watchdog_if.slave wd
);

  localparam int PC_W    = popcnt_w(CHANNELS);
  localparam int SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  state_e             state_q, state_d;
  fail_code_e         code_q, code_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cfg_q;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   com_q, com_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [PC_W-1:0]    pop;
  logic [SUM_W-1:0]   com_sum;
  logic [CNT_W-1:0]   com_sat;
  logic [CNT_W-1:0]   cyc_sat;
  logic               live;
  logic               any_err;
  logic               halt_hit;

  sim_watchdog_popcnt #(.CHANNELS(CHANNELS)) u_popcnt (
    .bits_i  (wd.valid),
    .count_o (pop)
  );

  // Saturating counter arithmetic; the wide sum exposes any carry out.
  assign com_sum  = SUM_W'(com_q) + SUM_W'(pop);
  assign com_sat  = (com_sum[SUM_W-1:CNT_W] != '0) ? '1 : com_sum[CNT_W-1:0];
  assign cyc_sat  = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
  assign live     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign any_err  = wd.mon_error || wd.mem_error;
  assign halt_hit = |(wd.halt & wd.valid);

  // Next-state logic; in RUN the priority is error, then halt, then timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    code_d  = code_q;
    timer_d = timer_q;
    drain_d = drain_q;
    cyc_d   = cyc_q;
    com_d   = com_q;
    done_d  = done_q;
    pass_d  = pass_q;

    if (live) begin
      cyc_d = cyc_sat;
      com_d = com_sat;
    end

    unique case (state_q)
      ST_RUN: begin
        if (any_err) begin
          state_d = ST_DRAIN;
          code_d  = wd.mon_error ? FC_MON : FC_MEM;
          drain_d = DRAIN_LOAD;
        end else if (halt_hit) begin
          state_d = ST_PASS;
          pass_d  = 1'b1;
          done_d  = 1'b1;
        end else if (timer_q == '0) begin
          state_d = ST_FAIL;
          code_d  = FC_TIMEOUT;
          done_d  = 1'b1;
        end else if ((IDLE_MODE != 0) && (|wd.valid)) begin
          timer_d = cfg_q;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        // Halts and later errors are ignored; the latched code stands.
        if (drain_q == '0) begin
          state_d = ST_FAIL;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: ; // PASS and FAIL hold until reset
    endcase
  end

  // State registers with synchronous reset that restarts the run.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_RUN;
      code_q  <= FC_NONE;
      timer_q <= wd.timeout_cfg;
      cfg_q   <= wd.timeout_cfg;
      drain_q <= '0;
      cyc_q   <= '0;
      com_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      timer_q <= timer_d;
      drain_q <= drain_d;
      cyc_q   <= cyc_d;
      com_q   <= com_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign wd.done         = done_q;
  assign wd.pass         = pass_q;
  assign wd.fail_code    = code_q;
  assign wd.cycle_count  = cyc_q;
  assign wd.commit_count = com_q;

endmodule
